// File: rtl/verily_core.sv
// verily_core: board-demo LED controller.
// Shows the slide switches directly on the LEDs (pass-through), or one of four
// animated patterns. The patterns step once per prescaler tick. Each debounced
// press of the joystick select button reverses the animation direction.
//
// Ports:
//   clk         system clock, single domain
//   reset       synchronous, active-high reset
//   switch[7:0] async slide switches: [7] pass-through, [2] pause, [1:0] pattern select
//   joy_select  async joystick select button, active high, bouncy
//   led[7:0]    registered LED drive, 1 = lit
module verily_core #(
    parameter int unsigned CLK_DIV         = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] switch,
    input  logic       joy_select,
    output logic [7:0] led
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        M_CNT  = 3'd0,
        M_ROT  = 3'd1,
        M_SCAN = 3'd2,
        M_LFSR = 3'd3,
        M_PASS = 3'd4
    } mode_t;

    typedef enum logic {
        SCAN_LEFT  = 1'b0,
        SCAN_RIGHT = 1'b1
    } scan_dir_t;

    // Two-flop synchronisers
    logic [7:0] sw_meta, sw_s;
    logic       joy_meta, joy_s;

    // Debouncer and direction
    logic          deb;
    logic [DW-1:0] deb_cnt;
    logic          dir;

    // Prescaler, mode tracking, pattern registers
    logic [PW-1:0] presc;
    mode_t         mode_q;
    logic [7:0]    cnt, rot, scan, lfsr;
    scan_dir_t     scan_dir;

    mode_t      mode_c;
    logic       tick_c;
    logic       mode_chg_c;
    logic       adv_c;
    logic       joy_diff_c;
    logic       deb_accept_c;
    logic       press_c;
    logic       lfsr_fb_c;
    logic [7:0] pat_c;

    // Decode mode, tick, debounce acceptance and LED source
    always_comb begin
        mode_c       = sw_s[7] ? M_PASS : mode_t'({1'b0, sw_s[1:0]});
        tick_c       = (presc == PRESC_MAX);
        mode_chg_c   = (mode_c != mode_q);
        // A mode change reloads the new pattern and suppresses the tick in that cycle
        adv_c        = tick_c && !sw_s[2] && !mode_chg_c;
        joy_diff_c   = (joy_s != deb);
        deb_accept_c = joy_diff_c && (deb_cnt == DEB_MAX);
        // Press fires in the same cycle the debounced level goes 0 -> 1
        press_c      = deb_accept_c && joy_s;
        lfsr_fb_c    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        pat_c        = sw_s;
        case (mode_c)
            M_CNT:   pat_c = cnt;
            M_ROT:   pat_c = rot;
            M_SCAN:  pat_c = scan;
            M_LFSR:  pat_c = lfsr;
            default: pat_c = sw_s;
        endcase
    end

    // All state, including the scan bounce state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta  <= 8'h00;
            sw_s     <= 8'h00;
            joy_meta <= 1'b0;
            joy_s    <= 1'b0;
            deb      <= 1'b0;
            deb_cnt  <= '0;
            dir      <= 1'b0;
            presc    <= '0;
            mode_q   <= M_CNT;
            cnt      <= 8'h00;
            rot      <= 8'h01;
            scan     <= 8'h01;
            scan_dir <= SCAN_LEFT;
            lfsr     <= 8'h01;
            led      <= 8'h00;
        end else begin
            sw_meta  <= switch;
            sw_s     <= sw_meta;
            joy_meta <= joy_select;
            joy_s    <= joy_meta;

            if (deb_accept_c) begin
                deb     <= joy_s;
                deb_cnt <= '0;
            end else if (joy_diff_c) begin
                deb_cnt <= deb_cnt + 1'b1;
            end else begin
                deb_cnt <= '0;
            end

            // Old dir is used by any pattern step in this same cycle
            if (press_c) begin
                dir <= ~dir;
            end

            presc  <= tick_c ? '0 : presc + 1'b1;
            mode_q <= mode_c;

            case (mode_c)
                M_CNT: begin
                    if (mode_chg_c)  cnt <= 8'h00;
                    else if (adv_c)  cnt <= dir ? cnt - 8'd1 : cnt + 8'd1;
                end
                M_ROT: begin
                    if (mode_chg_c)  rot <= 8'h01;
                    else if (adv_c)  rot <= dir ? {rot[0], rot[7:1]} : {rot[6:0], rot[7]};
                end
                M_SCAN: begin
                    if (mode_chg_c) begin
                        scan     <= 8'h01;
                        scan_dir <= SCAN_LEFT;
                    end else if (adv_c) begin
                        // Turn around on reaching an end so each end bit is lit for one tick
                        if (scan_dir == SCAN_LEFT) begin
                            if (scan[7]) begin
                                scan     <= {1'b0, scan[7:1]};
                                scan_dir <= SCAN_RIGHT;
                            end else begin
                                scan <= {scan[6:0], 1'b0};
                            end
                        end else begin
                            if (scan[0]) begin
                                scan     <= {scan[6:0], 1'b0};
                                scan_dir <= SCAN_LEFT;
                            end else begin
                                scan <= {1'b0, scan[7:1]};
                            end
                        end
                    end
                end
                M_LFSR: begin
                    if (mode_chg_c)  lfsr <= 8'h01;
                    else if (adv_c)  lfsr <= {lfsr[6:0], lfsr_fb_c};
                end
                default: ;
            endcase

            led <= pat_c;
        end
    end

endmodule

// File: tb/tb_verily_core.sv
module tb_verily_core;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEB     = 4;
    localparam int          PASS    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] switch;
    logic       joy_select;
    logic [7:0] led;

    int errors = 0;
    int checks = 0;

    // Model state: selected mode, expected current pattern value, direction, scan heading
    int         m_mode;
    logic [7:0] m_cur;
    bit         m_dir;
    bit         m_scan_up;

    verily_core #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .switch     (switch),
        .joy_select (joy_select),
        .led        (led)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_next(input int m, input logic [7:0] v, input bit d, input bit up);
        logic [7:0] r;
        case (m)
            0:       r = d ? v - 8'd1 : v + 8'd1;
            1:       r = d ? {v[0], v[7:1]} : {v[6:0], v[7]};
            2:       r = up ? {v[6:0], 1'b0} : {1'b0, v[7:1]};
            default: r = {v[6:0], ^(v & 8'hB8)};
        endcase
        return r;
    endfunction

    // Observe the next 'steps' LED changes; each must be the model's next value, one tick apart
    task automatic track(input int steps);
        logic [7:0] exp_v;
        int n;
        for (int i = 0; i < steps; i++) begin
            exp_v = model_next(m_mode, m_cur, m_dir, m_scan_up);
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (led === m_cur && n < 3 * int'(CLK_DIV));
            checks++;
            if (led !== exp_v) begin
                errors++;
                $display("FAIL step mode=%0d i=%0d dir=%0d led=%h expected=%h", m_mode, i, m_dir, led, exp_v);
            end
            if (i > 0) begin
                checks++;
                if (n != int'(CLK_DIV)) begin
                    errors++;
                    $display("FAIL tick_interval mode=%0d i=%0d cycles=%0d expected=%0d", m_mode, i, n, CLK_DIV);
                end
            end
            if (m_mode == 2) begin
                if (exp_v == 8'h80) m_scan_up = 1'b0;
                if (exp_v == 8'h01) m_scan_up = 1'b1;
            end
            m_cur = exp_v;
        end
    endtask

    task automatic go_pass();
        logic [7:0] v;
        v = 8'h80 | 8'($urandom);
        @(negedge clk);
        switch = v;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (led !== v) begin
            errors++;
            $display("FAIL pass_through led=%h expected=%h", led, v);
        end
        m_mode = PASS;
    endtask

    // Caller guarantees the new mode differs from the current one, so the pattern reloads
    task automatic enter_mode(input int m);
        @(negedge clk);
        switch = {1'b0, 4'($urandom), 1'b0, 2'(m)};
        repeat (4) @(posedge clk);
        #1;
        m_mode    = m;
        m_cur     = (m == 0) ? 8'h00 : 8'h01;
        m_scan_up = 1'b1;
        checks++;
        if (led !== m_cur) begin
            errors++;
            $display("FAIL reload mode=%0d led=%h expected=%h", m, led, m_cur);
        end
    endtask

    task automatic press(input int len);
        @(negedge clk);
        joy_select = 1'b1;
        repeat (len) @(negedge clk);
        joy_select = 1'b0;
        repeat (12) @(negedge clk);
        if (len >= int'(DEB)) m_dir = ~m_dir;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        joy_select = 1'b0;
        switch     = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL reset_led led=%h expected=00", led);
        end
        @(negedge clk);
        reset  = 1'b0;
        switch = 8'h80;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL sync_latency_early led=%h expected=00", led);
        end
        @(posedge clk); #1;
        checks++;
        if (led !== 8'h80) begin
            errors++;
            $display("FAIL sync_latency_third_edge led=%h expected=80", led);
        end
        m_mode = PASS;
        m_dir  = 1'b0;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 6; i++) go_pass();
    endtask

    task automatic test_patterns();
        int m;
        for (int r = 0; r < 6; r++) begin
            go_pass();
            m = int'($urandom_range(0, 3));
            enter_mode(m);
            track((m == 2) ? 16 : 6 + int'($urandom_range(0, 8)));
        end
    endtask

    task automatic test_scan_lfsr();
        go_pass();
        enter_mode(2);
        track(14);
        checks++;
        if (led !== 8'h01) begin
            errors++;
            $display("FAIL scan_period led=%h expected=01", led);
        end
        go_pass();
        enter_mode(3);
        track(5);
        checks++;
        if (led !== 8'h23) begin
            errors++;
            $display("FAIL lfsr_seq5 led=%h expected=23", led);
        end
    endtask

    task automatic test_direction();
        go_pass();
        press(5);
        press(3);
        enter_mode(1);
        track(8);
        go_pass();
        enter_mode(0);
        track(4);
        go_pass();
        for (int i = 0; i < 5; i++) press(int'($urandom_range(1, 7)));
        enter_mode(1);
        track(9);
        go_pass();
        enter_mode(0);
        track(5);
    endtask

    task automatic test_pause();
        bit ok;
        for (int r = 0; r < 3; r++) begin
            go_pass();
            enter_mode(int'($urandom_range(0, 3)));
            track(3);
            @(negedge clk);
            switch = switch | 8'h04;
            ok = 1'b1;
            repeat (24) begin
                @(posedge clk); #1;
                if (led !== m_cur) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL pause_hold mode=%0d led=%h expected=%h", m_mode, led, m_cur);
            end
            @(negedge clk);
            switch = switch & 8'hFB;
            track(4);
        end
    endtask

    task automatic test_mode_restart();
        go_pass();
        enter_mode(1);
        track(4);
        enter_mode(0);
        track(3);
        enter_mode(1);
        track(3);
    endtask

    task automatic test_reset_mid();
        go_pass();
        press(6);
        enter_mode(3);
        track(4);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid led=%h expected=00", led);
        end
        @(negedge clk);
        reset  = 1'b0;
        switch = 8'h01;
        m_dir  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        m_mode    = 1;
        m_cur     = 8'h01;
        checks++;
        if (led !== 8'h01) begin
            errors++;
            $display("FAIL reset_mid_rot_start led=%h expected=01", led);
        end
        track(9);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_patterns();
        test_scan_lfsr();
        test_direction();
        test_pause();
        test_mode_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
